// File: rtl/noc_pkg.sv
// Shared defaults and helpers for the parameterised router.
// Build option: PARAM_ROUTER_STATS_EN adds drop/forward statistics to param_router.
package noc_pkg;

  localparam int DEF_SIZE             = 8;
  localparam int DEF_PORT_COUNT       = 4;
  localparam int DEF_DESTINATION_BITS = 3;
  localparam int DEF_DEPTH_LOG2       = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/param_router_if.sv
// Bundles the router's input, output and routing-table signals.
// Handshake: a flit moves on a rising edge where req and ack are both high; the
// offering side keeps req/data stable until that edge, the taking side may drop ack freely.
interface param_router_if
  import noc_pkg::*;
#(
  parameter int SIZE             = DEF_SIZE,
  parameter int PORT_COUNT       = DEF_PORT_COUNT,
  parameter int DESTINATION_BITS = DEF_DESTINATION_BITS
);

  logic [PORT_COUNT-1:0]                  rx_req;
  logic [PORT_COUNT-1:0]                  rx_ack;
  logic [PORT_COUNT*SIZE-1:0]             rx_data;
  logic [PORT_COUNT-1:0]                  tx_req;
  logic [PORT_COUNT-1:0]                  tx_ack;
  logic [PORT_COUNT*SIZE-1:0]             tx_data;
  logic [PORT_COUNT*SIZE-1:0]             table_addr;
  logic [PORT_COUNT*DESTINATION_BITS-1:0] table_data;

  // master is the surrounding fabric, slave is the router itself
  modport master (
    output rx_req, rx_data, tx_ack, table_data,
    input  rx_ack, tx_req, tx_data, table_addr
  );

  modport slave (
    input  rx_req, rx_data, tx_ack, table_data,
    output rx_ack, tx_req, tx_data, table_addr
  );

endinterface

// File: rtl/router_fifo.sv
// Per-input flit queue; pointers carry one extra wrap bit to tell full from empty.
module router_fifo #(
  parameter int SIZE       = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] head,
  output logic            full,
  output logic            empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PW'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/param_router.sv
// Input-queued crossbar router with per-output round-robin arbitration and registered outputs.
// Build option: PARAM_ROUTER_STATS_EN adds drop_count and fwd_count statistics ports.
module param_router
  import noc_pkg::*;
#(
  parameter int SIZE             = DEF_SIZE,
  parameter int PORT_COUNT       = DEF_PORT_COUNT,
  parameter int DESTINATION_BITS = DEF_DESTINATION_BITS,
  parameter int DEPTH_LOG2       = DEF_DEPTH_LOG2
) (
  input  logic                         clk,
  input  logic                         reset,
  param_router_if.slave                bus
`ifdef PARAM_ROUTER_STATS_EN
  ,
  output logic [15:0]                  drop_count,
  output logic [PORT_COUNT*16-1:0]     fwd_count
`endif
);

  localparam int RR_W = (PORT_COUNT > 1) ? clog2(PORT_COUNT) : 1;
  localparam int DW1  = DESTINATION_BITS + 1;

  logic                        ready_q;
  logic [PORT_COUNT-1:0]       full;
  logic [PORT_COUNT-1:0]       empty;
  logic [PORT_COUNT-1:0]       push;
  logic [PORT_COUNT-1:0]       pop;
  logic [PORT_COUNT-1:0]       drop;
  logic [SIZE-1:0]             head     [PORT_COUNT];
  logic [DESTINATION_BITS-1:0] dest     [PORT_COUNT];
  logic [RR_W-1:0]             rr       [PORT_COUNT];
  logic [RR_W-1:0]             winner   [PORT_COUNT];
  logic [PORT_COUNT-1:0]       gnt_vld;
  logic [PORT_COUNT-1:0]       out_free;
  logic [PORT_COUNT-1:0]       tx_req_q;
  logic [SIZE-1:0]             tx_data_q [PORT_COUNT];

  // ready_q holds rx_ack low until the first edge after reset release
  assign bus.rx_ack = {PORT_COUNT{ready_q}} & ~full;
  assign push       = bus.rx_req & bus.rx_ack;
  assign bus.tx_req = tx_req_q;

  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_in
    router_fifo #(
      .SIZE       (SIZE),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[p]),
      .pop   (pop[p]),
      .din   (bus.rx_data[p*SIZE +: SIZE]),
      .head  (head[p]),
      .full  (full[p]),
      .empty (empty[p])
    );

    assign dest[p] = bus.table_data[p*DESTINATION_BITS +: DESTINATION_BITS];
    // a head routed past the last output is thrown away without arbitration
    assign drop[p] = !empty[p] && ({1'b0, dest[p]} >= DW1'(PORT_COUNT));
  end

  always_comb begin
    for (int i = 0; i < PORT_COUNT; i++) begin
      bus.table_addr[i*SIZE +: SIZE] = head[i];
      bus.tx_data[i*SIZE +: SIZE]    = tx_data_q[i];
    end
  end

  always_comb begin
    int idx;
    idx      = 0;
    gnt_vld  = '0;
    out_free = '0;
    pop      = drop;
    for (int o = 0; o < PORT_COUNT; o++) begin
      winner[o]   = '0;
      out_free[o] = !tx_req_q[o] || bus.tx_ack[o];
      for (int i = 0; i < PORT_COUNT; i++) begin
        idx = int'(rr[o]) + i;
        if (idx >= PORT_COUNT) idx = idx - PORT_COUNT;
        if (!gnt_vld[o] && !empty[idx] && (dest[idx] == DESTINATION_BITS'(o))) begin
          gnt_vld[o] = 1'b1;
          winner[o]  = RR_W'(idx);
        end
      end
      if (gnt_vld[o] && out_free[o]) pop[winner[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b0;
      tx_req_q <= '0;
      for (int o = 0; o < PORT_COUNT; o++) begin
        rr[o]        <= '0;
        tx_data_q[o] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      for (int o = 0; o < PORT_COUNT; o++) begin
        if (out_free[o]) begin
          if (gnt_vld[o]) begin
            tx_req_q[o]  <= 1'b1;
            tx_data_q[o] <= head[winner[o]];
            rr[o]        <= (winner[o] == RR_W'(PORT_COUNT - 1)) ? '0 : winner[o] + RR_W'(1);
          end else begin
            tx_req_q[o] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef PARAM_ROUTER_STATS_EN
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int p = 0; p < PORT_COUNT; p++) drop_sum = drop_sum + 17'(drop[p]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
      fwd_count  <= '0;
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int o = 0; o < PORT_COUNT; o++) begin
        if (tx_req_q[o] && bus.tx_ack[o])
          fwd_count[o*16 +: 16] <= fwd_count[o*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_router.sv
// Bench for param_router: directed scenarios plus a queue-based delivery model checked every cycle.
module tb_param_router;
  import noc_pkg::*;

  localparam int SIZE = 8;
  localparam int PC   = 4;
  localparam int DB   = 3;
  localparam int DL   = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  param_router_if #(.SIZE(SIZE), .PORT_COUNT(PC), .DESTINATION_BITS(DB)) bus ();

`ifdef PARAM_ROUTER_STATS_EN
  logic [15:0]      drop_count;
  logic [PC*16-1:0] fwd_count;
`endif

  param_router #(
    .SIZE(SIZE), .PORT_COUNT(PC), .DESTINATION_BITS(DB), .DEPTH_LOG2(DL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PARAM_ROUTER_STATS_EN
    ,
    .drop_count (drop_count),
    .fwd_count  (fwd_count)
`endif
  );

  // routing table: combinational lookup keyed by the flit value
  logic [DB-1:0] route_mem [256];
  for (genvar g = 0; g < PC; g++) begin : g_tab
    assign bus.table_data[g*DB +: DB] = route_mem[bus.table_addr[g*SIZE +: SIZE]];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [SIZE-1:0] exp_q [PC*PC][$];
  int  acc_cnt = 0;
  int  del_cnt = 0;
  int  drop_model = 0;
  int  fwd_model [PC];
  bit  mon_en = 1'b0;
  logic [SIZE-1:0] got1 [$];
  int  got1_cyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < PC*PC; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < PC*PC; i++) exp_q[i].delete();
    acc_cnt = 0; del_cnt = 0; drop_model = 0;
    for (int o = 0; o < PC; o++) fwd_model[o] = 0;
  endtask

  // compare process: sampled at negedge, describes the transfers of the coming rising edge
  initial begin
    logic [PC-1:0]   prev_req;
    logic [PC-1:0]   prev_ack;
    logic [SIZE-1:0] prev_data [PC];
    bit              prev_vld;
    logic [SIZE-1:0] d;
    logic [DB-1:0]   r;
    bit              hit;
    prev_vld = 1'b0;
    prev_req = '0;
    prev_ack = '0;
    for (int o = 0; o < PC; o++) prev_data[o] = '0;
    forever begin
      @(negedge clk);
      if (!reset || !mon_en) begin
        prev_vld = 1'b0;
      end else begin
        for (int o = 0; o < PC; o++) begin
          d = bus.tx_data[o*SIZE +: SIZE];
          if (prev_vld && prev_req[o] && !prev_ack[o]) begin
            check($sformatf("hold_req_o%0d", o), 32'(bus.tx_req[o]), 32'd1);
            check($sformatf("hold_data_o%0d", o), 32'(d), 32'(prev_data[o]));
          end else if (prev_vld && !prev_req[o] && !bus.tx_req[o]) begin
            check($sformatf("idle_data_o%0d", o), 32'(d), 32'(prev_data[o]));
          end
          if (bus.tx_req[o] && bus.tx_ack[o]) begin
            hit = 1'b0;
            for (int p = 0; p < PC; p++) begin
              if (!hit && exp_q[p*PC+o].size() > 0 && exp_q[p*PC+o][0] == d) begin
                void'(exp_q[p*PC+o].pop_front());
                hit = 1'b1;
              end
            end
            checks++;
            if (!hit) begin
              failures++;
              $display("FAIL deliver_o%0d actual=%0h required=head flit of some input queued for this output (t=%0t)",
                       o, d, $time);
            end
            del_cnt++;
            fwd_model[o]++;
            if (o == 1) begin
              got1.push_back(d);
              got1_cyc.push_back(cyc);
            end
          end
          prev_data[o] = d;
        end
        for (int p = 0; p < PC; p++) begin
          if (bus.rx_req[p] && bus.rx_ack[p]) begin
            d = bus.rx_data[p*SIZE +: SIZE];
            r = route_mem[d];
            acc_cnt++;
            if (int'(r) >= PC) drop_model++;
            else exp_q[p*PC + int'(r)].push_back(d);
          end
        end
        prev_req = bus.tx_req;
        prev_ack = bus.tx_ack;
        prev_vld = 1'b1;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int p, input logic req, input logic [SIZE-1:0] data);
    bus.rx_req[p]                = req;
    bus.rx_data[p*SIZE +: SIZE]  = data;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [SIZE-1:0] exp_t2 [12];
    int k [PC];
    int n;
    int bound;

    bus.rx_req  = '0;
    bus.rx_data = '0;
    bus.tx_ack  = '0;
    for (int i = 0; i < 256; i++) route_mem[i] = '0;
    for (int o = 0; o < PC; o++) fwd_model[o] = 0;

    // reset state
    step(3);
    check("reset_rx_ack",  32'(bus.rx_ack),  32'h0);
    check("reset_tx_req",  32'(bus.tx_req),  32'h0);
    check("reset_tx_data", bus.tx_data,      32'h0);
`ifdef PARAM_ROUTER_STATS_EN
    check("reset_drop_count", 32'(drop_count), 32'h0);
`endif
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("rx_ack_before_first_edge", 32'(bus.rx_ack), 32'h0);
    @(posedge clk);
    #1 check("rx_ack_after_first_edge", 32'(bus.rx_ack), 32'hF);
    mon_en = 1'b1;

    // single flit 5A, input 0 -> output 2
    route_mem[8'h5A] = 3'd2;
    bus.tx_ack = '1;
    set_rx(0, 1'b1, 8'h5A);
    step(1);
    set_rx(0, 1'b0, 8'h00);
    check("t1_tx_req_after_accept", 32'(bus.tx_req), 32'h0);
    step(1);
    check("t1_tx_req_after_grant", 32'(bus.tx_req), 32'h4);
    check("t1_tx_data2", 32'(bus.tx_data[2*SIZE +: SIZE]), 32'h5A);
    step(1);
    check("t1_tx_req_after_take", 32'(bus.tx_req), 32'h0);

    // all inputs to output 1, ack tied high: strict rotation, one flit per cycle
    exp_t2 = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31,
               8'h02, 8'h12, 8'h22, 8'h32};
    for (int p = 0; p < PC; p++)
      for (int j = 0; j < 3; j++) route_mem[p*16 + j] = 3'd1;
    got1.delete();
    got1_cyc.delete();
    for (int p = 0; p < PC; p++) k[p] = 0;
    bound = 0;
    while ((k[0] < 3 || k[1] < 3 || k[2] < 3 || k[3] < 3) && bound < 40) begin
      for (int p = 0; p < PC; p++)
        set_rx(p, k[p] < 3, SIZE'(p*16 + k[p]));
      @(negedge clk);
      for (int p = 0; p < PC; p++) if (bus.rx_req[p] && bus.rx_ack[p]) k[p]++;
      @(posedge clk);
      #1;
      bound++;
    end
    for (int p = 0; p < PC; p++) set_rx(p, 1'b0, 8'h00);
    bound = 0;
    while (got1.size() < 12 && bound < 40) begin
      step(1);
      bound++;
    end
    check("t2_delivered", 32'(got1.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < got1.size()) begin
        check($sformatf("t2_order_%0d", i), 32'(got1[i]), 32'(exp_t2[i]));
        check($sformatf("t2_cycle_%0d", i), 32'(got1_cyc[i] - got1_cyc[0]), 32'(i));
      end
    end

    // backpressure: 6 flits input 2 -> output 3, ack low for 10 cycles
    for (int j = 0; j < 6; j++) route_mem[8'h60 + j] = 3'd3;
    bus.tx_ack[3] = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      set_rx(2, n < 6, SIZE'(8'h60 + n));
      @(negedge clk);
      if (bus.rx_req[2] && bus.rx_ack[2]) n++;
      @(posedge clk);
      #1;
    end
    check("t3_accepted_while_stalled", 32'(n), 32'd5);
    check("t3_rx_ack2_low", 32'(bus.rx_ack[2]), 32'd0);
    check("t3_tx_req3_high", 32'(bus.tx_req[3]), 32'd1);
    check("t3_tx_data3", 32'(bus.tx_data[3*SIZE +: SIZE]), 32'h60);
    bus.tx_ack[3] = 1'b1;
    bound = 0;
    while (n < 6 && bound < 20) begin
      set_rx(2, 1'b1, SIZE'(8'h60 + n));
      @(negedge clk);
      if (bus.rx_req[2] && bus.rx_ack[2]) n++;
      @(posedge clk);
      #1;
      bound++;
    end
    set_rx(2, 1'b0, 8'h00);
    check("t3_all_accepted", 32'(n), 32'd6);
    bound = 0;
    while (!(model_empty() && bus.tx_req == '0) && bound < 30) begin
      step(1);
      bound++;
    end
    check("t3_drained", 32'(model_empty()), 32'd1);

    // out-of-range destination is dropped
    route_mem[8'h77] = 3'd7;
    set_rx(1, 1'b1, 8'h77);
    step(1);
    set_rx(1, 1'b0, 8'h00);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t4_no_tx_%0d", c), 32'(bus.tx_req), 32'h0);
      step(1);
    end
    check("t4_model_drops", 32'(drop_model), 32'd1);
`ifdef PARAM_ROUTER_STATS_EN
    check("t4_drop_count", 32'(drop_count), 32'd1);
`endif

    // reset mid-transfer
    route_mem[8'h11] = 3'd0;
    bus.tx_ack[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_rx(0, 1'b1, 8'h11);
      step(1);
    end
    set_rx(0, 1'b0, 8'h00);
    step(2);
    check("t5_tx_req0_before_reset", 32'(bus.tx_req[0]), 32'd1);
    #3;
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    check("t5_tx_req_in_reset",  32'(bus.tx_req), 32'h0);
    check("t5_rx_ack_in_reset",  32'(bus.rx_ack), 32'h0);
    check("t5_tx_data_in_reset", bus.tx_data,     32'h0);
    model_flush();
    bus.tx_ack = '1;
    step(2);
    @(negedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1);
      check($sformatf("t5_no_stale_%0d", c), 32'(bus.tx_req), 32'h0);
    end
`ifdef PARAM_ROUTER_STATS_EN
    check("t5_drop_count_cleared", 32'(drop_count), 32'd0);
`endif

    // random traffic with random output stalls
    for (int i = 0; i < 256; i++) route_mem[i] = DB'($urandom_range(0, 5));
    bound = 0;
    while (acc_cnt < 1000 && bound < 20000) begin
      bus.rx_req = PC'($urandom_range(0, 15));
      for (int p = 0; p < PC; p++) bus.rx_data[p*SIZE +: SIZE] = SIZE'($urandom_range(0, 255));
      bus.tx_ack = PC'($urandom_range(0, 15));
      step(1);
      bound++;
    end
    bus.rx_req = '0;
    bus.tx_ack = '1;
    bound = 0;
    while (!(model_empty() && bus.tx_req == '0) && bound < 200) begin
      step(1);
      bound++;
    end
    check("t6_enough_flits", 32'(acc_cnt >= 1000), 32'd1);
    check("t6_model_empty", 32'(model_empty()), 32'd1);
    check("t6_conservation", 32'(acc_cnt), 32'(del_cnt + drop_model));
`ifdef PARAM_ROUTER_STATS_EN
    check("t6_drop_count", 32'(drop_count), 32'(drop_model));
    for (int o = 0; o < PC; o++)
      check($sformatf("t6_fwd_count_o%0d", o), 32'(fwd_count[o*16 +: 16]), 32'(fwd_model[o]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/param_router.md
PARAM_ROUTER -- requirements
Module: param_router

Interface
REQ-001 Parameter SIZE, default 8; flit width in bits.
REQ-002 Parameter PORT_COUNT, default 4; number of input ports and number of output ports.
REQ-003 Parameter DESTINATION_BITS, default 3; routing-table result width; SHALL be at least clog2(PORT_COUNT).
REQ-004 Parameter DEPTH_LOG2, default 2; each input FIFO holds 2^DEPTH_LOG2 flits.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rx_req  input  PORT_COUNT  per-input flit offered.
REQ-008 rx_ack  output  PORT_COUNT  per-input flit accepted.
REQ-009 rx_data  input  PORT_COUNT*SIZE  per-input flit; port p occupies bits [p*SIZE +: SIZE].
REQ-010 tx_req  output  PORT_COUNT  per-output flit offered.
REQ-011 tx_ack  input  PORT_COUNT  per-output flit taken.
REQ-012 tx_data  output  PORT_COUNT*SIZE  per-output flit; sliced as rx_data.
REQ-013 table_addr  output  PORT_COUNT*SIZE  per-input lookup address, equal to that FIFO's head flit.
REQ-014 table_data  input  PORT_COUNT*DESTINATION_BITS  per-input destination output port; combinational and valid in the same cycle as table_addr.

Function
REQ-015 A transfer on any req/ack pair SHALL occur at a rising edge where both req and ack are high.
REQ-016 rx_ack[p] SHALL be high when FIFO p is not full, with no bypass when full, even if a pop occurs in the same cycle.
REQ-017 An accepted flit SHALL be written to the tail of FIFO p; pointers wrap modulo 2^DEPTH_LOG2, and occupancy is tracked with one extra bit so full and empty are distinguished.
REQ-018 Input p SHALL request output o when FIFO p is non-empty and table_data[p] == o.
REQ-019 Output o SHALL be free when tx_req[o] is low, or when tx_req[o] and tx_ack[o] are both high in the current cycle.
REQ-020 A free output with one or more requesters SHALL grant exactly one input, chosen round-robin starting at pointer rr[o].
REQ-021 On a grant, the arbiter SHALL pop the winning head flit, register it into tx_data[o], assert tx_req[o] next cycle, and set rr[o] to (winner+1) mod PORT_COUNT.
REQ-022 While tx_req[o] is high and tx_ack[o] is low, tx_req[o] and tx_data[o] SHALL hold stable.
REQ-023 A free output with no requester SHALL drop tx_req[o] low at the next edge, and tx_data[o] SHALL hold its last value.
REQ-024 A completing transfer and a new grant on the same output in one cycle SHALL give back-to-back flits, sustaining one flit per cycle per output.
REQ-025 Minimum latency SHALL be 2 edges: accepted at edge N, head visible after N, granted at N+1, tx_req high after N+1.
REQ-026 A head with table_data[p] >= PORT_COUNT SHALL be popped and discarded in one cycle with no output activity.
REQ-027 Different inputs SHALL be granted to different outputs in the same cycle; this requires no extra logic because each head has one destination.
REQ-028 Flit order per input-output pair SHALL be preserved.

Reset
REQ-029 While reset is low, all FIFOs SHALL be empty, all rr pointers 0, tx_req all 0, tx_data all 0, and stats counters 0.
REQ-030 While reset is low, rx_ack SHALL be all 0.
REQ-031 rx_ack SHALL assert at the first rising edge after reset deasserts.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered and in-flight flits immediately.

Configuration
REQ-033 With PARAM_ROUTER_STATS_EN defined, output drop_count [15:0] SHALL count discarded flits and saturate at 16'hFFFF.
REQ-034 With PARAM_ROUTER_STATS_EN defined, output fwd_count [PORT_COUNT*16-1:0] SHALL count completed tx transfers per output, wrapping.
REQ-035 Without PARAM_ROUTER_STATS_EN, these ports and counters SHALL be absent, and drop behaviour SHALL be unchanged.

Structure
REQ-036 Package noc_pkg SHALL hold the default SIZE, PORT_COUNT, DESTINATION_BITS and DEPTH_LOG2 values, and a clog2 function.
REQ-037 The input queue SHALL be sub-module router_fifo (SIZE, DEPTH_LOG2; push, pop, head, full, empty), instantiated PORT_COUNT times.

Verification
REQ-038 After reset, a single flit 8'h5A on input 0 routed to output 2 -> tx_req[2] high 2 edges after acceptance, tx_data[2] = 8'h5A, other tx_req low.
REQ-039 Inputs 0..3 all target output 1 with tx_ack[1] tied high -> grants in order 0,1,2,3,0..., one flit per cycle, no loss.
REQ-040 tx_ack[3] held low for 10 cycles with 6 flits queued on input 2 for output 3 -> rx_ack[2] low after 5 accepted (DEPTH_LOG2=2: 4 in FIFO plus 1 in tx register), tx_data[3] stable, all delivered in order once ack rises.
REQ-041 table_data returns 7 for input 1 -> flit discarded, no tx_req, drop_count = 1 when STATS_EN is defined.
REQ-042 Reset pulled low while flits are queued and tx_req[0] is high -> tx_req and rx_ack drop to 0 immediately, and no stale flit appears after reset release.
REQ-043 Over 1000 random flits with random tx_ack stalls -> per-input/output order preserved, with flit count = delivered + dropped.
